// File: rtl/fetch_pipe.sv
// fetch_pipe: sequential PC generator feeding a DEPTH-entry in-order fetch queue.
// Requests go out over a valid/ready port, in-order responses fill queue entries,
// and filled entries are handed to decode. A redirect flushes the queue and
// remembers how many in-flight responses must be thrown away.
module fetch_pipe #(
  parameter int             N        = 64,
  parameter int             IW       = 32,
  parameter int             DEPTH    = 4,
  parameter logic [N-1:0]   RESET_PC = '0,
  parameter int             INC      = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          redirect_F,
  input  logic [N-1:0]  redirect_pc_F,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [N-1:0]  imem_req_addr,
  input  logic          imem_rsp_valid,
  input  logic [IW-1:0] imem_rsp_data,
  output logic          inst_valid_D,
  input  logic          inst_ready_D,
  output logic [IW-1:0] inst_D,
  output logic [N-1:0]  pc_D
);
  localparam int           AW      = $clog2(DEPTH);
  localparam int           CW      = $clog2(DEPTH + 1);
  localparam logic [N-1:0] INC_N   = N'(INC);
  localparam logic [CW:0]  DEPTH_W = (CW + 1)'(DEPTH);

  logic [N-1:0]     pc_q, pc_d;
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [AW-1:0]    fill_q, fill_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    drop_cnt_q, drop_cnt_d;
  logic [DEPTH-1:0] filled_q, filled_d;

  // Payload storage; validity is carried by filled_q, so no reset is needed here.
  logic [N-1:0]     pc_mem   [DEPTH];
  logic [IW-1:0]    inst_mem [DEPTH];

  logic             req_fire;
  logic             pop_fire;
  logic             rsp_fill;
  logic [CW-1:0]    filled_cnt;
  logic [CW-1:0]    unfilled_cnt;
  logic [CW+1:0]    drop_sum;

  // Count filled entries; allocated minus filled gives responses still owed to the queue.
  always_comb begin
    filled_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      filled_cnt = filled_cnt + CW'(filled_q[i]);
    end
    unfilled_cnt = count_q - filled_cnt;
  end

  // Port outputs and handshake events.
  always_comb begin
    imem_req_valid = !reset && !redirect_F &&
                     (({1'b0, count_q} + {1'b0, drop_cnt_q}) < DEPTH_W);
    imem_req_addr  = pc_q;
    inst_valid_D   = (count_q != '0) && filled_q[head_q];
    inst_D         = inst_valid_D ? inst_mem[head_q] : '0;
    pc_D           = inst_valid_D ? pc_mem[head_q] : '0;
    req_fire       = imem_req_valid && imem_req_ready;
    pop_fire       = inst_valid_D && inst_ready_D && !redirect_F;
    rsp_fill       = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_F;
  end

  // Next-state: redirect flushes everything, otherwise allocate / fill / pop.
  always_comb begin
    pc_d       = pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    filled_d   = filled_q;
    drop_sum   = '0;
    if (redirect_F) begin
      pc_d     = redirect_pc_F;
      head_d   = '0;
      tail_d   = '0;
      fill_d   = '0;
      count_d  = '0;
      filled_d = '0;
      // Every unfilled entry still has a response coming; one arriving now is already gone.
      drop_sum = {2'b00, drop_cnt_q} + {2'b00, unfilled_cnt};
      if (imem_rsp_valid && (drop_sum != '0)) begin
        drop_sum = drop_sum - (CW + 2)'(1);
      end
      drop_cnt_d = drop_sum[CW-1:0];
    end else begin
      if (req_fire) begin
        pc_d             = pc_q + INC_N;
        tail_d           = tail_q + AW'(1);
        filled_d[tail_q] = 1'b0;
      end
      if (imem_rsp_valid) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - CW'(1);
        end else begin
          filled_d[fill_q] = 1'b1;
          fill_d           = fill_q + AW'(1);
        end
      end
      if (pop_fire) begin
        head_d           = head_q + AW'(1);
        filled_d[head_q] = 1'b0;
      end
      count_d = count_q + CW'(req_fire) - CW'(pop_fire);
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
      filled_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      filled_q   <= filled_d;
    end
  end

  // Payload writes: PC at allocation, instruction when its response lands.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pc_mem[tail_q] <= pc_q;
    end
    if (rsp_fill) begin
      inst_mem[fill_q] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_pipe.sv
// Bench for fetch_pipe: in-order random-latency memory plus an epoch-tagged
// reference model of what should be requested and delivered.
`timescale 1ns/1ps
module tb_fetch_pipe;
  localparam int           N        = 32;
  localparam int           IW       = 32;
  localparam int           DEPTH    = 4;
  localparam int           INC      = 4;
  localparam logic [N-1:0] RESET_PC = '0;

  logic          clk            = 1'b0;
  logic          reset          = 1'b0;
  logic          redirect_F     = 1'b0;
  logic [N-1:0]  redirect_pc_F  = '0;
  logic          imem_req_valid;
  logic          imem_req_ready = 1'b0;
  logic [N-1:0]  imem_req_addr;
  logic          imem_rsp_valid = 1'b0;
  logic [IW-1:0] imem_rsp_data  = '0;
  logic          inst_valid_D;
  logic          inst_ready_D   = 1'b0;
  logic [IW-1:0] inst_D;
  logic [N-1:0]  pc_D;

  always #5 clk = ~clk;

  fetch_pipe #(.N(N), .IW(IW), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .INC(INC)) dut (
    .clk(clk), .reset(reset),
    .redirect_F(redirect_F), .redirect_pc_F(redirect_pc_F),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid_D(inst_valid_D), .inst_ready_D(inst_ready_D),
    .inst_D(inst_D), .pc_D(pc_D)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: each accepted request belongs to an epoch; a redirect or
  // reset starts a new epoch and everything older becomes a stale response.
  typedef struct { logic [N-1:0] addr; int epoch; int due; } mreq_t;
  mreq_t        mq[$];
  int           epoch       = 0;
  int           cyc         = 0;
  int           live_alloc  = 0;   // accepted in this epoch, not yet delivered
  int           live_filled = 0;   // answered in this epoch, not yet delivered
  int           lat_min     = 1;
  int           lat_max     = 1;
  logic [N-1:0] exp_pc      = RESET_PC;
  logic [N-1:0] exp_dpc     = RESET_PC;

  function automatic logic [IW-1:0] inst_of(input logic [N-1:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  function automatic int stale_cnt();
    int s = 0;
    foreach (mq[i]) if (mq[i].epoch != epoch) s++;
    return s;
  endfunction

  function automatic logic model_req_valid();
    return !reset && !redirect_F && ((live_alloc + stale_cnt()) < DEPTH);
  endfunction

  // Model update at each rising edge, from pre-edge inputs and model state.
  initial forever begin
    @(posedge clk);
    if (!reset) begin
      logic  fire;
      logic  pop;
      mreq_t e;
      fire = model_req_valid() && imem_req_ready;
      pop  = (live_filled > 0) && inst_ready_D && !redirect_F;
      if (imem_rsp_valid && mq.size() > 0) begin
        if (mq[0].epoch == epoch && !redirect_F) live_filled++;
        void'(mq.pop_front());
      end
      if (redirect_F) begin
        epoch++;
        live_alloc  = 0;
        live_filled = 0;
        exp_pc      = redirect_pc_F;
        exp_dpc     = redirect_pc_F;
      end else begin
        if (fire) begin
          e.addr  = imem_req_addr;
          e.epoch = epoch;
          e.due   = cyc + $urandom_range(lat_max, lat_min);
          mq.push_back(e);
          exp_pc = exp_pc + INC;
          live_alloc++;
        end
        if (pop) begin
          $display("cyc %0d deliver pc=%08h inst=%08h", cyc, pc_D, inst_D);
          live_alloc--;
          live_filled--;
          exp_dpc = exp_dpc + INC;
        end
      end
    end
    cyc++;
  end

  // Asynchronous reset abandons everything in flight.
  initial forever begin
    @(posedge reset);
    mq.delete();
    epoch++;
    live_alloc  = 0;
    live_filled = 0;
    exp_pc      = RESET_PC;
    exp_dpc     = RESET_PC;
  end

  // In-order memory: the oldest request answers once its latency has elapsed.
  initial forever begin
    @(negedge clk);
    if (!reset && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  task automatic test_reset();
    #2 reset = 1'b1;
    @(negedge clk); #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
    checks++; if (inst_valid_D !== 1'b0) begin errors++; $display("FAIL rst_inst_valid got=%b exp=0", inst_valid_D); end
    checks++; if (imem_req_addr !== RESET_PC) begin errors++; $display("FAIL rst_addr got=%h exp=%h", imem_req_addr, RESET_PC); end
    checks++; if (inst_D !== '0) begin errors++; $display("FAIL rst_inst got=%h exp=0", inst_D); end
    checks++; if (pc_D !== '0) begin errors++; $display("FAIL rst_pc got=%h exp=0", pc_D); end
    @(negedge clk); #2 reset = 1'b0;
  endtask

  task automatic test_stream();
    int pops_obs = 0;
    lat_min = 1; lat_max = 1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk); #1;
      imem_req_ready = 1'b1; inst_ready_D = 1'b1;
      #1;
      checks++;
      if (imem_req_valid !== model_req_valid()) begin errors++; $display("FAIL stream_req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, model_req_valid()); end
      if (model_req_valid()) begin
        checks++;
        if (imem_req_addr !== exp_pc) begin errors++; $display("FAIL stream_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, exp_pc); end
      end
      checks++;
      if (inst_valid_D !== (live_filled > 0)) begin errors++; $display("FAIL stream_inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid_D, live_filled > 0); end
      if (live_filled > 0) begin
        checks++;
        if (pc_D !== exp_dpc || inst_D !== inst_of(exp_dpc)) begin errors++; $display("FAIL stream_head cyc=%0d got=%h/%h exp=%h/%h", cyc, pc_D, inst_D, exp_dpc, inst_of(exp_dpc)); end
      end
      if (k >= 10 && inst_valid_D && inst_ready_D) pops_obs++;
    end
    checks++;
    if (pops_obs !== 20) begin errors++; $display("FAIL stream_rate got=%0d exp=20", pops_obs); end
  endtask

  task automatic test_backpressure();
    int fires = 0;
    int pops_obs = 0;
    int fires_rel = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1; imem_req_ready = 1'b0; inst_ready_D = 1'b1;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      imem_req_ready = 1'b1; inst_ready_D = 1'b0;
      #1;
      if (imem_req_valid && imem_req_ready) fires++;
      checks++;
      if (imem_req_valid !== model_req_valid()) begin errors++; $display("FAIL bp_req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, model_req_valid()); end
    end
    checks++; if (fires !== DEPTH) begin errors++; $display("FAIL bp_accepts got=%0d exp=%0d", fires, DEPTH); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_stall got=%b exp=0", imem_req_valid); end
    for (int k = 0; k < 15; k++) begin
      @(negedge clk); #1;
      imem_req_ready = 1'b1; inst_ready_D = 1'b1;
      #1;
      checks++;
      if (imem_req_valid !== model_req_valid()) begin errors++; $display("FAIL bp_rel_req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, model_req_valid()); end
      if (model_req_valid()) begin
        checks++;
        if (imem_req_addr !== exp_pc) begin errors++; $display("FAIL bp_rel_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, exp_pc); end
      end
      checks++;
      if (inst_valid_D !== (live_filled > 0)) begin errors++; $display("FAIL bp_rel_inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid_D, live_filled > 0); end
      if (live_filled > 0) begin
        checks++;
        if (pc_D !== exp_dpc || inst_D !== inst_of(exp_dpc)) begin errors++; $display("FAIL bp_rel_head cyc=%0d got=%h/%h exp=%h/%h", cyc, pc_D, inst_D, exp_dpc, inst_of(exp_dpc)); end
      end
      if (inst_valid_D && inst_ready_D) pops_obs++;
      if (imem_req_valid && imem_req_ready) fires_rel++;
    end
    checks++; if (pops_obs < DEPTH) begin errors++; $display("FAIL bp_drain got=%0d exp>=%0d", pops_obs, DEPTH); end
    checks++; if (fires_rel == 0) begin errors++; $display("FAIL bp_resume got=0 exp>0"); end
  endtask

  task automatic test_redirect();
    logic seen = 1'b0;
    lat_min = 3; lat_max = 3;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1; imem_req_ready = 1'b0; inst_ready_D = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1; imem_req_ready = 1'b1;
    end
    @(negedge clk); #1;
    imem_req_ready = 1'b0; redirect_F = 1'b1; redirect_pc_F = 32'h100;
    #1;
    checks++; if (live_alloc !== 2 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_setup outstanding=%0d req_valid=%b exp=2/0", live_alloc, imem_req_valid); end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      redirect_F = 1'b0; imem_req_ready = 1'b1; inst_ready_D = 1'b1;
      #1;
      checks++;
      if (imem_req_valid !== model_req_valid()) begin errors++; $display("FAIL redir_req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, model_req_valid()); end
      if (model_req_valid()) begin
        checks++;
        if (imem_req_addr !== exp_pc) begin errors++; $display("FAIL redir_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, exp_pc); end
      end
      checks++;
      if (inst_valid_D !== (live_filled > 0)) begin errors++; $display("FAIL redir_inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid_D, live_filled > 0); end
      if (live_filled > 0) begin
        checks++;
        if (pc_D !== exp_dpc || inst_D !== inst_of(exp_dpc)) begin errors++; $display("FAIL redir_head cyc=%0d got=%h/%h exp=%h/%h", cyc, pc_D, inst_D, exp_dpc, inst_of(exp_dpc)); end
      end
      if (!seen && inst_valid_D) begin
        seen = 1'b1;
        checks++;
        if (pc_D !== 32'h100) begin errors++; $display("FAIL redir_first_pc got=%h exp=00000100", pc_D); end
      end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL redir_no_delivery got=0 exp=1"); end
  endtask

  task automatic test_redirect_collide();
    logic found = 1'b0;
    lat_min = 1; lat_max = 1;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk); #1;
      imem_req_ready = 1'b1; inst_ready_D = 1'b1;
      if (imem_rsp_valid && live_filled > 0 && k > 3) begin
        found = 1'b1;
        redirect_F = 1'b1; redirect_pc_F = 32'h200;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL coll_req_in_redirect got=%b exp=0", imem_req_valid); end
      end
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL coll_timeout got=0 exp=1"); end
    @(negedge clk); #1;
    redirect_F = 1'b0;
    #1;
    checks++; if (inst_valid_D !== 1'b0) begin errors++; $display("FAIL coll_empty got=%b exp=0", inst_valid_D); end
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL coll_req_valid got=%b exp=1", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h200) begin errors++; $display("FAIL coll_addr got=%h exp=00000200", imem_req_addr); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #2;
      checks++;
      if (imem_req_valid !== model_req_valid()) begin errors++; $display("FAIL coll_req_valid2 cyc=%0d got=%b exp=%b", cyc, imem_req_valid, model_req_valid()); end
      if (live_filled > 0) begin
        checks++;
        if (pc_D !== exp_dpc || inst_D !== inst_of(exp_dpc)) begin errors++; $display("FAIL coll_head cyc=%0d got=%h/%h exp=%h/%h", cyc, pc_D, inst_D, exp_dpc, inst_of(exp_dpc)); end
      end
    end
  endtask

  task automatic test_wrap();
    logic saw_zero = 1'b0;
    @(negedge clk); #1;
    redirect_F = 1'b1; redirect_pc_F = 32'hFFFF_FFE8;
    lat_min = 1; lat_max = 3;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk); #1;
      redirect_F     = 1'b0;
      imem_req_ready = 1'($urandom_range(1, 0));
      inst_ready_D   = ($urandom_range(3, 0) != 0);
      #1;
      checks++;
      if (imem_req_valid !== model_req_valid()) begin errors++; $display("FAIL wrap_req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, model_req_valid()); end
      if (model_req_valid()) begin
        checks++;
        if (imem_req_addr !== exp_pc) begin errors++; $display("FAIL wrap_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, exp_pc); end
      end
      checks++;
      if (inst_valid_D !== (live_filled > 0)) begin errors++; $display("FAIL wrap_inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid_D, live_filled > 0); end
      if (live_filled > 0) begin
        checks++;
        if (pc_D !== exp_dpc || inst_D !== inst_of(exp_dpc)) begin errors++; $display("FAIL wrap_head cyc=%0d got=%h/%h exp=%h/%h", cyc, pc_D, inst_D, exp_dpc, inst_of(exp_dpc)); end
      end
      if (imem_req_valid && imem_req_ready && imem_req_addr == '0) saw_zero = 1'b1;
    end
    checks++; if (saw_zero !== 1'b1) begin errors++; $display("FAIL wrap_to_zero got=0 exp=1"); end
  endtask

  task automatic test_async_reset();
    lat_min = 2; lat_max = 2;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1; imem_req_ready = 1'b1; inst_ready_D = 1'b1;
    end
    @(negedge clk); #3;
    reset = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL arst_req_valid got=%b exp=0", imem_req_valid); end
    checks++; if (inst_valid_D !== 1'b0) begin errors++; $display("FAIL arst_inst_valid got=%b exp=0", inst_valid_D); end
    checks++; if (imem_req_addr !== RESET_PC) begin errors++; $display("FAIL arst_addr got=%h exp=%h", imem_req_addr, RESET_PC); end
    checks++; if (pc_D !== '0 || inst_D !== '0) begin errors++; $display("FAIL arst_head got=%h/%h exp=0/0", pc_D, inst_D); end
    @(negedge clk); #3;
    reset = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin errors++; $display("FAIL arst_restart got=%b/%h exp=1/%h", imem_req_valid, imem_req_addr, RESET_PC); end
    for (int k = 0; k < 15; k++) begin
      @(negedge clk); #2;
      checks++;
      if (imem_req_valid !== model_req_valid()) begin errors++; $display("FAIL arst_req_valid2 cyc=%0d got=%b exp=%b", cyc, imem_req_valid, model_req_valid()); end
      if (model_req_valid()) begin
        checks++;
        if (imem_req_addr !== exp_pc) begin errors++; $display("FAIL arst_addr2 cyc=%0d got=%h exp=%h", cyc, imem_req_addr, exp_pc); end
      end
      if (live_filled > 0) begin
        checks++;
        if (pc_D !== exp_dpc || inst_D !== inst_of(exp_dpc)) begin errors++; $display("FAIL arst_head2 cyc=%0d got=%h/%h exp=%h/%h", cyc, pc_D, inst_D, exp_dpc, inst_of(exp_dpc)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_collide();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
